// File: rtl/bsg_dmc_cfg_shadow_regs.sv
// Shadow/active config register bank for the DMC: byte-wide lines are staged in shadow and
// committed atomically while the controller is idle. Optional parity: define BSG_DMC_CFG_PARITY_EN.
module bsg_dmc_cfg_shadow_regs #(
    parameter int num_lines_p     = 14,
    parameter int line_width_p    = 8,
    parameter int ctrl_line_p     = 13,
    parameter int settle_cycles_p = 4
) (
    input  logic                                 dfi_clk_1x_i,
    input  logic                                 dfi_rst_n_i,
    input  logic [num_lines_p-1:0]               cfg_v_i,
    input  logic [num_lines_p*line_width_p-1:0]  cfg_data_i,
    input  logic                                 ctrl_idle_i,
    output logic [num_lines_p*line_width_p-1:0]  cfg_o,
    output logic                                 stall_o,
    output logic                                 sys_reset_o,
    output logic                                 stall_tx_o,
    output logic                                 commit_done_o,
    output logic [7:0]                           cfg_gen_o
`ifdef BSG_DMC_CFG_PARITY_EN
    ,
    output logic                                 parity_err_o
`endif
);

    localparam int LW = line_width_p;
    localparam int NW = num_lines_p * line_width_p;
    localparam int CW = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        APPLY  = 2'd2,
        SETTLE = 2'd3
    } state_e;

`ifdef BSG_DMC_CFG_PARITY_EN
    // MSB carries even parity over the lower bits, so a good line has zero overall XOR.
    function automatic logic line_par_ok(input logic [LW-1:0] line);
        return ~(^line);
    endfunction
`endif

    state_e          state_q, state_d;
    logic [NW-1:0]   shadow_q, shadow_d;
    logic [NW-1:0]   active_q, active_d;
    logic [1:0]      ctrl_sh_q, ctrl_sh_d;
    logic [1:0]      ctrl_act_q, ctrl_act_d;
    logic [7:0]      gen_q, gen_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            stall_q, stall_d;
    logic            done_q, done_d;
    logic            perr_q, perr_d;
    logic [num_lines_p-1:0] wr_ok_s;
    logic            req_set_s;
    logic            unused_ctrl_s;

    // Only bits 0..2 of the control line have meaning; the rest are deliberately ignored.
    assign unused_ctrl_s = ^cfg_data_i[ctrl_line_p*LW +: LW];

    // Write acceptance, shadow update and sticky parity error.
    always_comb begin
        wr_ok_s   = '0;
        shadow_d  = shadow_q;
        ctrl_sh_d = ctrl_sh_q;
        perr_d    = perr_q;
        for (int k = 0; k < num_lines_p; k++) begin
`ifdef BSG_DMC_CFG_PARITY_EN
            wr_ok_s[k] = cfg_v_i[k] & line_par_ok(cfg_data_i[k*LW +: LW]);
            if (cfg_v_i[k] && !wr_ok_s[k]) begin
                perr_d = 1'b1;
            end else begin
                perr_d = perr_d;
            end
`else
            wr_ok_s[k] = cfg_v_i[k];
`endif
            // The control slot in shadow stays zero; its meaningful bits live in ctrl_sh.
            if (wr_ok_s[k] && (k != ctrl_line_p)) begin
                shadow_d[k*LW +: LW] = cfg_data_i[k*LW +: LW];
            end else begin
                shadow_d[k*LW +: LW] = shadow_d[k*LW +: LW];
            end
        end
        if (wr_ok_s[ctrl_line_p]) begin
            ctrl_sh_d = cfg_data_i[ctrl_line_p*LW+1 +: 2];
        end else begin
            ctrl_sh_d = ctrl_sh_q;
        end
        req_set_s = wr_ok_s[ctrl_line_p] & cfg_data_i[ctrl_line_p*LW];
    end

    // Commit FSM: next state, apply datapath and registered flag outputs.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        ctrl_act_d = ctrl_act_q;
        gen_d      = gen_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        req_d      = req_q | req_set_s;
        case (state_q)
            IDLE: begin
                // Taking the request absorbs any same-cycle repeat: the apply still sees that write.
                if (req_q) begin
                    state_d = PEND;
                    req_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (ctrl_idle_i) begin
                    state_d = APPLY;
                end else begin
                    state_d = PEND;
                end
            end
            APPLY: begin
                active_d   = shadow_q;
                ctrl_act_d = ctrl_sh_q;
                gen_d      = gen_q + 8'd1;
                done_d     = 1'b1;
                cnt_d      = CW'(settle_cycles_p - 1);
                state_d    = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        stall_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge dfi_clk_1x_i or negedge dfi_rst_n_i) begin
        if (!dfi_rst_n_i) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            active_q   <= '0;
            ctrl_sh_q  <= 2'b00;
            ctrl_act_q <= 2'b00;
            gen_q      <= 8'd0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            ctrl_sh_q  <= ctrl_sh_d;
            ctrl_act_q <= ctrl_act_d;
            gen_q      <= gen_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
        end
    end

    assign cfg_o         = active_q;
    assign stall_o       = stall_q;
    assign sys_reset_o   = ctrl_act_q[0];
    assign stall_tx_o    = ctrl_act_q[1];
    assign commit_done_o = done_q;
    assign cfg_gen_o     = gen_q;
`ifdef BSG_DMC_CFG_PARITY_EN
    assign parity_err_o  = perr_q;
`else
    logic unused_perr_s;
    assign unused_perr_s = perr_q ^ perr_d;
`endif

endmodule
